// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: EX-stage branch inputs and redirect/flush outputs; perf counters exist only with BRU_PERF_CNT_EN.
interface branch_resolve_unit_if #(parameter int N = 32);
  logic         i_valid;
  logic         i_stall;
  logic         i_is_branch;
  logic         i_is_jal;
  logic         i_is_jalr;
  logic [2:0]   i_funct3;
  logic         i_br_less;
  logic         i_br_equal;
  logic [N-1:0] i_target;
  logic         o_br_un;
  logic         o_redirect;
  logic [N-1:0] o_redirect_pc;
  logic         o_flush;
  logic         o_misalign;
  logic         o_busy;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]  o_br_cnt;
  logic [31:0]  o_taken_cnt;
`endif
  modport master (
    output i_valid, i_stall, i_is_branch, i_is_jal, i_is_jalr, i_funct3, i_br_less, i_br_equal, i_target,
`ifdef BRU_PERF_CNT_EN
    input  o_br_cnt, o_taken_cnt,
`endif
    input  o_br_un, o_redirect, o_redirect_pc, o_flush, o_misalign, o_busy
  );
  modport slave (
    input  i_valid, i_stall, i_is_branch, i_is_jal, i_is_jalr, i_funct3, i_br_less, i_br_equal, i_target,
`ifdef BRU_PERF_CNT_EN
    output o_br_cnt, o_taken_cnt,
`endif
    output o_br_un, o_redirect, o_redirect_pc, o_flush, o_misalign, o_busy
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves B-type/JAL/JALR, registers a PC redirect and a timed wrong-path flush.
// Optional BRU_PERF_CNT_EN adds evaluated-branch and taken counters.
module branch_resolve_unit #(
  parameter int N            = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  branch_resolve_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
  state_t       state, state_nx;
  logic [3:0]   cnt, cnt_nx;
  logic         eval, cond, taken, is_b, misal;
  logic [N-1:0] tgt;
  logic         redirect_nx, flush_nx, misalign_nx;
  assign bus.o_br_un = bus.i_funct3[1];
  always_comb begin
    eval  = state == IDLE && bus.i_valid && !bus.i_stall;
    is_b  = bus.i_is_branch && !bus.i_is_jal && !bus.i_is_jalr;
    // funct3[2] selects the less-than family; funct3[0] inverts; 010/011 never taken
    cond  = bus.i_funct3[2] ? (bus.i_br_less ^ bus.i_funct3[0])
                            : (!bus.i_funct3[1] && (bus.i_br_equal ^ bus.i_funct3[0]));
    taken = bus.i_is_jalr || bus.i_is_jal || (bus.i_is_branch && cond);
    tgt   = bus.i_is_jalr ? {bus.i_target[N-1:1], 1'b0} : bus.i_target;
    misal = tgt[1:0] != 2'b00;
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:     state_nx = (eval && taken && !misal) ? REDIRECT : IDLE;
      REDIRECT: begin
        cnt_nx   = 4'(FLUSH_CYCLES - 1);
        state_nx = FLUSH_CYCLES == 1 ? IDLE : FLUSH;
      end
      FLUSH: begin
        cnt_nx   = cnt - 4'd1;
        state_nx = cnt <= 4'd1 ? IDLE : FLUSH;
      end
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    redirect_nx = state_nx == REDIRECT;
    flush_nx    = state_nx != IDLE;
    misalign_nx = eval && taken && misal;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.o_redirect    <= 1'b0;
      bus.o_redirect_pc <= '0;
      bus.o_flush       <= 1'b0;
      bus.o_misalign    <= 1'b0;
      bus.o_busy        <= 1'b0;
`ifdef BRU_PERF_CNT_EN
      bus.o_br_cnt      <= '0;
      bus.o_taken_cnt   <= '0;
`endif
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      bus.o_redirect <= redirect_nx;
      bus.o_flush    <= flush_nx;
      bus.o_busy     <= flush_nx;
      bus.o_misalign <= misalign_nx;
      if (state == IDLE && state_nx == REDIRECT) bus.o_redirect_pc <= tgt;
`ifdef BRU_PERF_CNT_EN
      if (eval && is_b) bus.o_br_cnt <= bus.o_br_cnt + 32'd1;
      if (eval && taken) bus.o_taken_cnt <= bus.o_taken_cnt + 32'd1;
`endif
    end
  end
endmodule
